dram_bit_reader: RTL
====================

Name: dram_bit_reader

Overview:
- Read-side engine for a 128x1 single-port distributed RAM with synchronous write and asynchronous read.
- Drives the RAM address and samples the RAM's 1-bit output once per clock.
- Packs consecutive bits LSB-first into DATA_W-bit words and presents them on a valid/ready output stream.
- Used to drain bit-tables and configuration bitmaps written through the RAM's write port.

Parameters:
- DATA_W, 8, bits per output word; legal range 1..16.
- LEN_W, 4, width of CMD_LEN; a command transfers CMD_LEN+1 words (1..2^LEN_W).

Ports:
- CLK  input  1  clock, rising edge; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- CMD_VALID  input  1  read command request.
- CMD_READY  output  1  engine idle and able to accept a command.
- CMD_ADDR  input  7  bit address of the first bit read.
- CMD_LEN  input  LEN_W  number of words minus one.
- RAM_A  output  7  registered address to the RAM A6..A0.
- RAM_O  input  1  RAM asynchronous read data O.
- M_VALID  output  1  output word valid.
- M_READY  input  1  downstream accepts the word.
- M_DATA  output  DATA_W  packed word; bit i = RAM[word_base+i].
- M_LAST  output  1  high with the final word of a command.
- BUSY  output  1  command in progress (state != IDLE).

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high, sampled only on the rising edge of CLK.
- Reset values: state=IDLE, RAM_A=0, M_VALID=0, M_DATA=0, M_LAST=0, BUSY=0, bit counter=0, word counter=0.
- CMD_READY = (state==IDLE) & ~RST; it is forced low while RST is high.
- IDLE state:
  - On edge T0 with CMD_VALID & CMD_READY: RAM_A<=CMD_ADDR, word counter<=CMD_LEN, bit counter<=0, M_DATA<=0, go to READ.
  - Otherwise CMD_VALID is ignored.
- READ state:
  - Each edge: M_DATA[bit_cnt]<=RAM_O, RAM_A<=RAM_A+1 (mod 128; 127 wraps to 0), bit_cnt<=bit_cnt+1.
  - The RAM is combinational, so RAM_O reflects the current RAM_A within the same cycle.
  - On the edge that samples bit DATA_W-1: go to OUT, set M_VALID<=1, set M_LAST<=(word counter==0).
- Word timing:
  - Bit j of the first word is sampled at edge T0+1+j.
  - M_VALID first rises after edge T0+DATA_W.
- OUT state:
  - M_DATA and M_LAST are held stable and RAM_A holds the next bit address while M_VALID=1 and M_READY=0.
  - On an edge with M_READY=1 and M_LAST=0: M_VALID<=0, word counter decrements, bit_cnt<=0, M_DATA<=0, go to READ.
  - On an edge with M_READY=1 and M_LAST=1: M_VALID<=0, M_LAST<=0, go to IDLE.
  - CMD_READY rises in the cycle after the handshake.
- Throughput: DATA_W+1 cycles per word with M_READY tied high. A new command is accepted no earlier than the cycle after the final handshake.
- Address continuity: word k of a command starts at (CMD_ADDR + k*DATA_W) mod 128. Reads wrap freely, and a command may cover more than 128 bits (the same RAM bits are read again).
- RAM contents changing mid-command: the engine samples whatever RAM_O shows at each edge and provides no coherency guarantee.
- RST at any point, including mid-word or with M_VALID high:
  - Next state is IDLE with all outputs at their reset values.
  - The partial word is discarded and no M_LAST is produced.
- RST has priority over command acceptance and over the output handshake in the same cycle.
- M_VALID must never drop without a handshake, except on RST.

Test Plan:
Bench uses a RAM128X1S-behaviour model, INIT=128'hF123456789ABCDEF_FEDCBA987654321A, with DATA_W=8.
- Single word: CMD_ADDR=0, CMD_LEN=0, M_READY=1 -> RAM_A steps 0..7; M_VALID rises 8 cycles after acceptance with M_DATA=8'h1A, M_LAST=1; CMD_READY returns high one cycle after the handshake.
- Unaligned: CMD_ADDR=4, CMD_LEN=0 -> M_DATA=8'h21, M_LAST=1.
- Wrap-around: CMD_ADDR=124, CMD_LEN=0 -> RAM_A sequence 124..127,0..3; M_DATA=8'hAF.
- Multi-word with backpressure: CMD_ADDR=0, CMD_LEN=2, M_READY low for 5 cycles on the second word -> words 8'h1A, 8'h32, 8'h54; M_LAST only on the third word; M_DATA and RAM_A stable while stalled; no word lost or duplicated.
- Reset mid-operation: CMD_ADDR=0, CMD_LEN=3, assert RST for 1 cycle at edge T0+4 -> the following cycle shows M_VALID=0, BUSY=0, RAM_A=0, CMD_READY=1; a fresh command with CMD_ADDR=4 then returns 8'h21.
- Command during busy: hold CMD_VALID high throughout a CMD_LEN=1 transfer -> CMD_READY stays low; the second command is accepted only after the M_LAST handshake; exactly 2 words are produced for the first command.

Source files
------------

// File: rtl/dram_bit_reader.sv
// dram_bit_reader
//   Read-side engine for a 128x1 distributed RAM (synchronous write,
//   asynchronous read). It walks the RAM address one bit per clock and packs
//   the bits LSB-first into DATA_W-bit words. Words leave on a valid/ready
//   stream, and M_LAST marks the final word of each command.
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   CMD_VALID  command request
//   CMD_READY  engine idle and accepting a command (low while RST is high)
//   CMD_ADDR   bit address of the first bit of the command
//   CMD_LEN    number of words minus one
//   RAM_A      registered RAM address
//   RAM_O      asynchronous RAM read data
//   M_VALID    output word valid
//   M_READY    downstream accepts the word
//   M_DATA     packed word, bit i = RAM[word_base + i]
//   M_LAST     final word of the command
//   BUSY       command in progress
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for a command, CMD_READY high
// S_READ | sampling one RAM bit per clock into M_DATA
// S_OUT  | word complete, holding M_VALID until the handshake
module dram_bit_reader #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [6:0]        CMD_ADDR,
  input  logic [LEN_W-1:0]  CMD_LEN,
  output logic [6:0]        RAM_A,
  input  logic              RAM_O,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DATA_W-1:0] M_DATA,
  output logic              M_LAST,
  output logic              BUSY
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [6:0]          ram_a_q, ram_a_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]    word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic                accept;

  assign CMD_READY = (state_q == S_IDLE) & ~RST;
  assign accept    = CMD_VALID & CMD_READY;

  always_comb begin
    state_d    = state_q;
    ram_a_d    = ram_a_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          ram_a_d    = CMD_ADDR;
          word_cnt_d = CMD_LEN;
          bit_cnt_d  = '0;
          m_data_d   = '0;
          state_d    = S_READ;
        end
      end

      S_READ: begin
        // RAM_O already reflects ram_a_q this cycle (combinational read).
        m_data_d[bit_cnt_q] = RAM_O;
        ram_a_d             = ram_a_q + 7'd1;
        bit_cnt_d           = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = S_OUT;
          m_valid_d = 1'b1;
          m_last_d  = (word_cnt_q == '0);
        end
      end

      S_OUT: begin
        // ram_a_q already points at the first bit of the next word.
        if (M_READY) begin
          m_valid_d = 1'b0;
          if (m_last_q) begin
            m_last_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            word_cnt_d = word_cnt_q - LEN_W'(1);
            bit_cnt_d  = '0;
            m_data_d   = '0;
            state_d    = S_READ;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      ram_a_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_a_q    <= ram_a_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
    end
  end

  assign RAM_A   = ram_a_q;
  assign M_VALID = m_valid_q;
  assign M_DATA  = m_data_q;
  assign M_LAST  = m_last_q;
  assign BUSY    = (state_q != S_IDLE);

endmodule
